// File: rtl/spram_banked_be.sv
// Banked simple dual-port RAM with byte-enable writes, optional output register,
// selectable read-during-write policy and a zero-clear sequence after reset.
module spram_banked_be #(
    parameter  int DWIDTH   = 32,
    parameter  int AWIDTH   = 10,
    parameter  int BANKS    = 1,
    parameter  int OUT_REG  = 0,
    parameter  int RDW_MODE = 0,
    localparam int BW       = DWIDTH / 8,
    localparam int FW       = AWIDTH + ((BANKS > 1) ? $clog2(BANKS) : 0)
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              rce,
    input  logic [FW-1:0]     ra,
    output logic [DWIDTH-1:0] rq,
    output logic              rq_valid,
    input  logic              wce,
    input  logic [FW-1:0]     wa,
    input  logic [DWIDTH-1:0] wd,
    input  logic [BW-1:0]     wbe,
    output logic              init_busy
);

    localparam int BSW   = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock0) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = RUN;
        end
    end

    assign init_busy = (state_q == CLEAR);

    logic rd_go, wr_go;
    assign rd_go = (state_q == RUN) & rce & ~reset;
    assign wr_go = (state_q == RUN) & wce & (|wbe) & ~reset;

    logic [AWIDTH-1:0] ra_word, wa_word;
    logic [BSW-1:0]    ra_bank, wa_bank;

    assign ra_word = ra[AWIDTH-1:0];
    assign wa_word = wa[AWIDTH-1:0];

    generate
        if (BANKS > 1) begin : g_bank_sel
            assign ra_bank = ra[FW-1:AWIDTH];
            assign wa_bank = wa[FW-1:AWIDTH];
        end else begin : g_single_bank
            assign ra_bank = '0;
            assign wa_bank = '0;
        end
    endgenerate

    // The clear sequence borrows the write port and hits every bank at once.
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_data;
    logic [BW-1:0]     mem_be;

    assign mem_addr = init_busy ? cnt_q : wa_word;
    assign mem_data = init_busy ? '0 : wd;
    assign mem_be   = init_busy ? '1 : wbe;

    logic [DWIDTH-1:0] bank_rdata [BANKS];

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            logic [DWIDTH-1:0] mem [DEPTH];
            logic [DWIDTH-1:0] rdata_q;
            logic              bank_we, bank_re;

            assign bank_we = init_busy | (wr_go & (wa_bank == BSW'(b)));
            assign bank_re = rd_go & (ra_bank == BSW'(b));

            // NOTE: the array itself has no reset so it maps onto block RAM; the clear FSM zeroes it.
            always_ff @(posedge clock0) begin
                if (bank_we) begin
                    for (int k = 0; k < BW; k++) begin
                        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_data[8*k +: 8];
                    end
                end
            end

            // Registered read samples the pre-write word, giving read-first natively.
            always_ff @(posedge clock0) begin
                if (reset)        rdata_q <= '0;
                else if (bank_re) rdata_q <= mem[ra_word];
            end

            assign bank_rdata[b] = rdata_q;
        end
    endgenerate

    logic [BSW-1:0]    rbank_q;
    logic              s1_valid_q;
    logic              fwd_hit_q;
    logic [DWIDTH-1:0] fwd_data_q;
    logic [BW-1:0]     fwd_be_q;

    always_ff @(posedge clock0) begin
        if (reset) begin
            rbank_q    <= '0;
            s1_valid_q <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
        end else begin
            s1_valid_q <= rd_go;
            if (rd_go) begin
                rbank_q    <= ra_bank;
                fwd_hit_q  <= wr_go & (wa == ra);
                fwd_data_q <= wd;
                fwd_be_q   <= wbe;
            end
        end
    end

    // Write-first merges the colliding write's enabled lanes over the old word.
    logic [DWIDTH-1:0] s1_data;

    always_comb begin
        s1_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (rbank_q == BSW'(b)) s1_data = bank_rdata[b];
        end
        for (int k = 0; k < BW; k++) begin
            if ((RDW_MODE == 1) && fwd_hit_q && fwd_be_q[k]) s1_data[8*k +: 8] = fwd_data_q[8*k +: 8];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] rq_q;
            logic              rq_valid_q;

            always_ff @(posedge clock0) begin
                if (reset) begin
                    rq_q       <= '0;
                    rq_valid_q <= 1'b0;
                end else begin
                    rq_valid_q <= s1_valid_q;
                    if (s1_valid_q) rq_q <= s1_data;
                end
            end

            assign rq       = rq_q;
            assign rq_valid = rq_valid_q;
        end else begin : g_no_out_reg
            assign rq       = s1_data;
            assign rq_valid = s1_valid_q;
        end
    endgenerate

endmodule

// File: doc/spram_banked_be.md
Name: spram_banked_be

Overview:
- Parametrised successor to the single-width, id-selected 32x1024 RAM.
- Simple dual-port synchronous RAM: one read port and one write port on a single clock.
- Generalised in data width, per-bank depth and bank count; the bank is selected from the upper address bits.
- Adds byte-enable writes, an optional output register, a selectable read-during-write policy, a read-valid strobe and a hardware zero-clear sequence after reset.
- Used as the generic on-chip buffer in front of datapath blocks.

Parameters:
- DWIDTH, 32: data width; must be a multiple of 8.
- AWIDTH, 10: per-bank address width; bank depth is 2**AWIDTH.
- BANKS, 1: bank count; power of 2, >= 1.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- RDW_MODE, 0: same-address read/write in one cycle; 0 = read-first (old data), 1 = write-first (merged new data).
- Derived: BW = DWIDTH/8. FW = AWIDTH + $clog2(BANKS), or AWIDTH when BANKS = 1.

Ports:
- clock0, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- rce, input, 1: read enable.
- ra, input, FW: read address; upper bits select the bank, lower AWIDTH bits select the word.
- rq, output, DWIDTH: read data.
- rq_valid, output, 1: one-cycle pulse, aligned with rq, for each accepted read.
- wce, input, 1: write enable.
- wa, input, FW: write address; decoded the same way as ra.
- wd, input, DWIDTH: write data.
- wbe, input, BW: byte enables; bit k enables wd[8k+7:8k].
- init_busy, output, 1: high while the clear sequence runs.

Behaviour:
- Clock and reset: one clock (clock0); reset is synchronous and active-high.
- Reset: on any clock0 edge with reset = 1:
  - state <= CLEAR, clear counter <= 0, init_busy <= 1;
  - rq <= 0, rq_valid <= 0, and the OUT_REG pipeline stage <= 0.
  - Memory contents are not touched by reset itself.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Each cycle writes 0 to word[cnt] in every bank simultaneously, then cnt++.
  - After 2**AWIDTH cycles (last write at cnt = 2**AWIDTH-1), moves to RUN and init_busy <= 0 on that edge.
  - rce and wce are ignored (dropped, not queued); rq_valid stays 0; rq holds its value.
- RUN, read:
  - A read is accepted when rce = 1.
  - OUT_REG = 0: rq = mem[ra] on the next edge, and rq_valid is high for that one cycle.
  - OUT_REG = 1: rq and rq_valid both appear one edge later (2 cycles total); back-to-back reads give one result per cycle.
  - With no read, rq holds its last value and rq_valid = 0.
- RUN, write:
  - Occurs when wce = 1 and wbe != 0.
  - Only the enabled byte lanes of mem[wa] are updated; wbe = 0 is a no-op.
- Collision (wce & rce, ra == wa, same cycle):
  - RDW_MODE = 0: rq returns the pre-write word.
  - RDW_MODE = 1: rq returns the post-write word (new bytes where wbe is set, old bytes elsewhere).
  - The memory is updated in both modes.
- Different addresses or different banks: the read and write are fully independent in the same cycle.
- Bank enables are decoded from the address; no id port and no cross-bank aliasing.
- Reset mid-CLEAR or mid-RUN:
  - Restarts CLEAR from cnt = 0 and discards any read in flight; no rq_valid is produced for it.
  - All words read 0 after the new CLEAR completes.
- Reset held for N cycles: CLEAR starts counting on the first edge with reset = 0.
- Address widths are exact powers of 2, so no out-of-range condition exists.
- Implementation note: the memory array is inferred per bank with registered read.

Test Plan:
- Init timing: AWIDTH=10, BANKS=1. Pulse reset for 1 cycle -> init_busy high for exactly 1024 cycles after reset drops. Then read ra=0x005 -> rq=0x00000000 with rq_valid one cycle later.
- Basic read/write: OUT_REG=0, write wa=0x005, wd=0xDEADBEEF, wbe=4'hF; next cycle rce with ra=0x005 -> rq=0xDEADBEEF and rq_valid=1 one cycle after rce. Repeat with OUT_REG=1 -> same data two cycles after rce; back-to-back reads of 0x005 and 0x006 give a 1-per-cycle rq_valid stream.
- Byte enables: over 0xDEADBEEF at 0x005, write wd=0x11223344, wbe=4'b0101 -> read returns 0xDE22BE44. A write with wbe=0 leaves the word unchanged.
- Collision: 0x005 holds 0xDEADBEEF; same cycle, wce and rce at 0x005 with wd=0x11223344, wbe=4'hF. RDW_MODE=0 -> rq=0xDEADBEEF. RDW_MODE=1 -> rq=0x11223344. A subsequent read returns 0x11223344 in both modes.
- Bank isolation: BANKS=4, write 0xAAAA0000 to 0x005 and 0xBBBB0000 to 0x405 -> reads return those values separately; 0x805 and 0xC05 read 0.
- Reset mid-operation: in RUN after the writes above, assert reset for 1 cycle while a read is in flight -> no rq_valid, rq=0, init_busy=1. rce pulses during CLEAR produce no rq_valid. After 1024 cycles, 0x005 and 0x405 read 0.
